// File: rtl/sc_run_ctrl_pkg.sv
// Shared state encodings, key indices and defaults for the run/halt/step controller.
package sc_run_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_HALT   = 3'd0,
      ST_RUN    = 3'd1,
      ST_STEP   = 3'd2,
      ST_RESUME = 3'd3,
      ST_BREAK  = 3'd4
   } run_state_t;

   localparam logic [15:0] DEFAULT_DEBOUNCE_CYCLES = 16'd50000;

   // Bit positions of the three keys inside the packed key/press vectors.
   localparam int KEY_RUN  = 0;
   localparam int KEY_STEP = 1;
   localparam int KEY_HALT = 2;
   localparam int NUM_KEYS = 3;

endpackage

// File: rtl/sc_key_debounce.sv
// One push-button path: 2-FF synchroniser, stability counter and a one-cycle
// pulse when the accepted level falls (press). Releases produce no pulse.
module sc_key_debounce
   import sc_run_ctrl_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic resetn,
   input  logic key_n,
   output logic press
);

   logic        sync1_reg;
   logic        sync2_reg;
   logic        level_reg;
   logic        press_reg;
   logic [15:0] cnt_reg;

   // cnt_reg holds how many consecutive samples already disagreed with the
   // accepted level; the DEBOUNCE_CYCLES-th disagreeing sample flips it.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         level_reg <= 1'b1;
         press_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= key_n;
         sync2_reg <= sync1_reg;
         press_reg <= 1'b0;
         if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == DEBOUNCE_CYCLES - 16'd1) begin
            level_reg <= sync2_reg;
            press_reg <= ~sync2_reg;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + 16'd1;
         end
      end
   end

   assign press = press_reg;

endmodule

// File: rtl/sc_run_ctrl.sv
// Run/halt/single-step clock-enable controller with instruction counter.
// Optional breakpoint support is built when SC_RUN_CTRL_BP_EN is defined.
module sc_run_ctrl
   import sc_run_ctrl_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic        RUN_ON_RESET    = 1'b0
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        key_run_n,
   input  logic        key_step_n,
   input  logic        key_halt_n,
   input  logic        count_clr,
   input  logic [31:0] pc,
   input  logic [31:0] bp_addr,
   input  logic        bp_en,
   output logic        cpu_en,
   output logic [2:0]  state,
   output logic        halted,
   output logic [31:0] instr_count
);

   localparam run_state_t RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_HALT;

   logic [NUM_KEYS-1:0] keys_n;
   logic [NUM_KEYS-1:0] press;
   run_state_t          state_reg;
   run_state_t          state_next;
   logic                bp_hit;
   logic [31:0]         count_reg;

   assign keys_n[KEY_RUN]  = key_run_n;
   assign keys_n[KEY_STEP] = key_step_n;
   assign keys_n[KEY_HALT] = key_halt_n;

   generate
      for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         sc_key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clock  (clock),
            .resetn (resetn),
            .key_n  (keys_n[gi]),
            .press  (press[gi])
         );
      end
   endgenerate

`ifdef SC_RUN_CTRL_BP_EN
   assign bp_hit = bp_en && (pc == bp_addr);
`else
   logic unused_bp;
   assign unused_bp = ^{pc, bp_addr, bp_en};
   assign bp_hit    = 1'b0;
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg <= RESET_STATE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Halt outranks step, which outranks run; a step press while running halts.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_HALT: begin
            if (press[KEY_HALT])      state_next = ST_HALT;
            else if (press[KEY_STEP]) state_next = ST_STEP;
            else if (press[KEY_RUN])  state_next = ST_RUN;
         end
         ST_RUN: begin
            if (press[KEY_HALT] || press[KEY_STEP]) state_next = ST_HALT;
            else if (bp_hit)                        state_next = ST_BREAK;
         end
         ST_STEP:   state_next = ST_HALT;
         ST_RESUME: state_next = ST_RUN;
         ST_BREAK: begin
            if (press[KEY_HALT])      state_next = ST_HALT;
            else if (press[KEY_STEP]) state_next = ST_STEP;
            else if (press[KEY_RUN])  state_next = ST_RESUME;
         end
         default: state_next = ST_HALT;
      endcase
   end

   // RESUME deliberately ignores bp_hit so the breakpoint instruction executes.
   always_comb begin
      cpu_en = 1'b0;
      halted = 1'b0;
      unique case (state_reg)
         ST_RUN:    cpu_en = ~bp_hit;
         ST_STEP:   cpu_en = 1'b1;
         ST_RESUME: cpu_en = 1'b1;
         ST_HALT:   halted = 1'b1;
         ST_BREAK:  halted = 1'b1;
         default:   halted = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count_reg <= '0;
      end else if (count_clr) begin
         count_reg <= '0;
      end else if (cpu_en) begin
         count_reg <= count_reg + 32'd1;
      end
   end

   assign state       = state_reg;
   assign instr_count = count_reg;

endmodule

// File: tb/tb_sc_run_ctrl.sv
// Directed-plus-random bench for sc_run_ctrl against a cycle-level behavioural model.
// Breakpoint expectations are enabled when SC_RUN_CTRL_BP_EN is defined.
module tb_sc_run_ctrl;

   localparam int D = 4;

   logic        clock = 1'b0;
   logic        resetn = 1'b1;
   logic        key_run_n = 1'b1;
   logic        key_step_n = 1'b1;
   logic        key_halt_n = 1'b1;
   logic        count_clr = 1'b0;
   logic [31:0] pc = 32'd0;
   logic [31:0] bp_addr = 32'h0000_0010;
   logic        bp_en = 1'b0;
   logic        d_cpu_en;
   logic [2:0]  d_state;
   logic        d_halted;
   logic [31:0] d_instr_count;

   sc_run_ctrl #(
      .DEBOUNCE_CYCLES (16'(D)),
      .RUN_ON_RESET    (1'b0)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .key_run_n   (key_run_n),
      .key_step_n  (key_step_n),
      .key_halt_n  (key_halt_n),
      .count_clr   (count_clr),
      .pc          (pc),
      .bp_addr     (bp_addr),
      .bp_en       (bp_en),
      .cpu_en      (d_cpu_en),
      .state       (d_state),
      .halted      (d_halted),
      .instr_count (d_instr_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // Reference model: states 0=halt 1=run 2=step 3=resume 4=break.
   logic [2:0]  m_state;
   logic [31:0] m_count;
   logic [2:0]  m_press;      // {halt, step, run}
   logic [2:0]  m_level;
   logic [2:0]  hist[$];      // key levels seen at recent clock edges
   bit          pc_auto = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_bp_hit();
`ifdef SC_RUN_CTRL_BP_EN
      return bp_en && (pc == bp_addr);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_cpu_en();
      if (m_state == 3'd1) return !m_bp_hit();
      return (m_state == 3'd2) || (m_state == 3'd3);
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, "_state"}, {29'd0, d_state}, {29'd0, m_state});
      chk({tag, "_cpu_en"}, {31'd0, d_cpu_en}, {31'd0, m_cpu_en()});
      chk({tag, "_halted"}, {31'd0, d_halted}, {31'd0, (m_state == 3'd0) || (m_state == 3'd4)});
      chk({tag, "_count"}, d_instr_count, m_count);
   endtask

   // One clock edge: advance the model with the inputs seen at the edge, then compare.
   task automatic tick();
      bit         en_pre;
      bit         all_diff;
      logic [2:0] ns;
      @(posedge clock);
      en_pre = m_cpu_en();
      ns = m_state;
      case (m_state)
         3'd0: if (m_press[2]) ns = 3'd0; else if (m_press[1]) ns = 3'd2; else if (m_press[0]) ns = 3'd1;
         3'd1: if (m_press[2] || m_press[1]) ns = 3'd0; else if (m_bp_hit()) ns = 3'd4;
         3'd2: ns = 3'd0;
         3'd3: ns = 3'd1;
         3'd4: if (m_press[2]) ns = 3'd0; else if (m_press[1]) ns = 3'd2; else if (m_press[0]) ns = 3'd3;
         default: ns = 3'd0;
      endcase
      if (count_clr) m_count = 32'd0;
      else if (en_pre) m_count = m_count + 32'd1;
      // A key level is accepted once the D synchronised samples (2 edges old) all disagree.
      hist.push_back({key_halt_n, key_step_n, key_run_n});
      if (hist.size() > D + 2) void'(hist.pop_front());
      for (int k = 0; k < 3; k++) begin
         all_diff = 1'b1;
         for (int j = 0; j < D; j++) if (hist[j][k] == m_level[k]) all_diff = 1'b0;
         m_press[k] = 1'b0;
         if (all_diff) begin
            m_level[k] = ~m_level[k];
            m_press[k] = (m_level[k] == 1'b0);
         end
      end
      m_state = ns;
      #1;
      check_outputs("cyc");
      if (pc_auto && en_pre) pc = pc + 32'd4;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      m_state = 3'd0;
      m_count = 32'd0;
      m_press = 3'b000;
      m_level = 3'b111;
      hist.delete();
      repeat (D + 2) hist.push_back(3'b111);
      #1;
      check_outputs("reset");
      @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         0: key_run_n = v;
         1: key_step_n = v;
         default: key_halt_n = v;
      endcase
   endtask

   task automatic press_key(input int k, input int n);
      set_key(k, 1'b0);
      repeat (n) tick();
      set_key(k, 1'b1);
      repeat (D + 4) tick();
   endtask

   initial begin
      // 1: reset into HALT and idle
      #2;
      do_reset();
      repeat (20) tick();
      chk("idle_halted", {31'd0, d_halted}, 32'd1);

      // 2: two single steps
      press_key(1, 10);
      chk("step1_count", d_instr_count, 32'd1);
      press_key(1, 10);
      chk("step2_count", d_instr_count, 32'd2);

      // 3: free run with a mid-run clear, then halt
      press_key(0, 6);
      repeat (40) tick();
      count_clr = 1'b1;
      tick();
      count_clr = 1'b0;
      chk("clr_count", d_instr_count, 32'd0);
      repeat (60) tick();
      press_key(2, 6);
      chk("run_halt_state", {29'd0, d_state}, 32'd0);

      // 4: short glitch ignored; simultaneous halt+run while running halts
      key_run_n = 1'b0;
      repeat (3) tick();
      key_run_n = 1'b1;
      repeat (D + 4) tick();
      chk("glitch_state", {29'd0, d_state}, 32'd0);
      press_key(0, 6);
      chk("run_again", {29'd0, d_state}, 32'd1);
      key_halt_n = 1'b0;
      key_run_n = 1'b0;
      repeat (6) tick();
      key_halt_n = 1'b1;
      key_run_n = 1'b1;
      repeat (D + 4) tick();
      chk("simul_state", {29'd0, d_state}, 32'd0);

      // Random key activity, clears and breakpoint matches
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) key_run_n = ~key_run_n;
         if ($urandom_range(0, 7) == 0) key_step_n = ~key_step_n;
         if ($urandom_range(0, 7) == 0) key_halt_n = ~key_halt_n;
         count_clr = ($urandom_range(0, 31) == 0);
         pc = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
         bp_en = 1'($urandom_range(0, 1));
         tick();
      end
      key_run_n = 1'b1;
      key_step_n = 1'b1;
      key_halt_n = 1'b1;
      count_clr = 1'b0;
      bp_en = 1'b0;
      repeat (D + 4) tick();
      press_key(2, 6);

      // 5: breakpoint at 0x10 with the pc advancing on each executed instruction
      pc = 32'd0;
      bp_addr = 32'h0000_0010;
      bp_en = 1'b1;
      pc_auto = 1'b1;
      press_key(0, 6);
`ifdef SC_RUN_CTRL_BP_EN
      chk("bp_break_state", {29'd0, d_state}, 32'd4);
      chk("bp_break_en", {31'd0, d_cpu_en}, 32'd0);
`endif
      press_key(0, 6);
      repeat (5) tick();
      chk("bp_run_state", {29'd0, d_state}, 32'd1);
      press_key(2, 6);
      bp_en = 1'b0;

      // 6: reset while running with a count of 37
      count_clr = 1'b1;
      tick();
      count_clr = 1'b0;
      press_key(0, 6);
      for (int i = 0; i < 200 && m_count != 32'd37; i++) tick();
      chk("count37", d_instr_count, 32'd37);
      #2;
      do_reset();
      chk("reset_count", d_instr_count, 32'd0);
      repeat (20) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
